// File: rtl/xbar_pkg.sv
// Shared definitions for the crossbar master-side arbiter: master indices,
// index width and the arbiter state encoding.
package xbar_pkg;

    localparam int N_MASTERS_MAX = 16;
    localparam int IDX_W         = 4;

    localparam logic [IDX_W-1:0] MASTER_IF  = 4'd0;
    localparam logic [IDX_W-1:0] MASTER_LSU = 4'd1;
    localparam logic [IDX_W-1:0] MASTER_DBG = 4'd2;
    localparam logic [IDX_W-1:0] MASTER_DMA = 4'd3;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/xbar_master_arbiter_rr_pick.sv
// Combinational masked round-robin priority encoder: returns the first set bit
// of (req & mask), scanning from last+1 upward with wrap at N.
module rr_pick
    import xbar_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    input  logic [IDX_W-1:0] last,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [N-1:0] eff;

    assign eff = req & mask;

    always_comb begin
        int c;
        c     = 0;
        found = 1'b0;
        idx   = '0;
        // k runs 1..N so that 'last' itself is examined last.
        for (int k = 1; k <= N; k++) begin
            c = (int'(last) + k) % N;
            if (!found && eff[c]) begin
                found = 1'b1;
                idx   = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/xbar_master_arbiter.sv
// Round-robin arbiter for the crossbar's single master-side path. Holds a grant
// while the owner's transaction is outstanding and forces hand-off after MAX_HOLD.
module xbar_master_arbiter
    import xbar_pkg::*;
#(
    parameter int N_MASTERS = 16,
    parameter int MAX_HOLD  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_MASTERS-1:0] request,
    input  logic                 busy,
    output logic [N_MASTERS-1:0] grant,
    output logic                 grant_valid,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 preempt
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    arb_state_t             state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
    logic [N_MASTERS-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
    logic                   preempt_q, preempt_d;

    logic [N_MASTERS-1:0]   own_oh;
    logic [N_MASTERS-1:0]   pick_mask;
    logic                   owner_req;
    logic                   contested;
    logic                   expired;
    logic [HW-1:0]          hold_inc;
    logic                   pick_found;
    logic [IDX_W-1:0]       pick_idx;

    assign own_oh    = N_MASTERS'(1) << owner_q;
    assign owner_req = |(request & own_oh);
    assign contested = |(request & ~own_oh);
    assign expired   = hold_cnt_q >= HOLD_MAX;
    assign hold_inc  = expired ? HOLD_MAX : hold_cnt_q + HW'(1);
    // While owning, the current owner never competes with itself.
    assign pick_mask = (state_q == ARB_OWN) ? ~own_oh : '1;

    rr_pick #(.N(N_MASTERS)) u_pick (
        .req   (request),
        .mask  (pick_mask),
        .last  (last_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        logic take;
        take       = 1'b0;
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        preempt_d  = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                take = pick_found;
            end
            ARB_OWN: begin
                if (busy) begin
                    hold_cnt_d = contested ? hold_inc : '0;
                end else if (!owner_req) begin
                    // Release wins over expiry, so no preempt pulse here.
                    if (pick_found) begin
                        take = 1'b1;
                    end else begin
                        state_d    = ARB_IDLE;
                        hold_cnt_d = '0;
                    end
                end else if (expired && contested) begin
                    take      = 1'b1;
                    preempt_d = 1'b1;
                end else begin
                    hold_cnt_d = contested ? hold_inc : '0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        if (take) begin
            state_d    = ARB_OWN;
            owner_d    = pick_idx;
            last_d     = pick_idx;
            hold_cnt_d = '0;
        end

        grant_d     = (state_d == ARB_OWN) ? (N_MASTERS'(1) << owner_d) : '0;
        grant_idx_d = (state_d == ARB_OWN) ? owner_d : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            owner_q     <= '0;
            last_q      <= IDX_W'(N_MASTERS - 1);
            hold_cnt_q  <= '0;
            grant_q     <= '0;
            grant_idx_q <= '0;
            preempt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            hold_cnt_q  <= hold_cnt_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            preempt_q   <= preempt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = (state_q == ARB_OWN);
    assign grant_idx   = grant_idx_q;
    assign preempt     = preempt_q;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert ($onehot0(grant_q));
        end
    end

endmodule

// File: tb/tb_xbar_master_arbiter.sv
// Scoreboard bench for xbar_master_arbiter (N_MASTERS=16, MAX_HOLD=4): directed
// vectors push expected outputs; a monitor pops and compares after each edge.
module tb_xbar_master_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] request;
    logic        busy;
    logic [15:0] grant;
    logic        grant_valid;
    logic [3:0]  grant_idx;
    logic        preempt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] g;
        logic        p;
        string       nm;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    xbar_master_arbiter #(.N_MASTERS(16), .MAX_HOLD(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .request     (request),
        .busy        (busy),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .preempt     (preempt)
    );

    function automatic logic [3:0] idx_of(input logic [15:0] g);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 15; i >= 0; i--) if (g[i]) r = 4'(i);
        return r;
    endfunction

    // Drive one cycle of inputs and record the outputs expected after the next edge.
    task automatic step(input logic r, input logic [15:0] rq, input logic b,
                        input logic [15:0] g, input logic p, input string nm);
        exp_t e;
        @(negedge clk);
        rst_n   = r;
        request = rq;
        busy    = b;
        e.g  = g;
        e.p  = p;
        e.nm = nm;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({grant, grant_valid, grant_idx, preempt} !==
                    {e.g, |e.g, idx_of(e.g), e.p}) begin
                    failures++;
                    $display("FAIL %s: got grant=%h valid=%b idx=%0d preempt=%b, want grant=%h valid=%b idx=%0d preempt=%b",
                             e.nm, grant, grant_valid, grant_idx, preempt,
                             e.g, |e.g, idx_of(e.g), e.p);
                end
            end
        end
    end

    initial begin : stim
        rst_n   = 1'b0;
        request = 16'h0000;
        busy    = 1'b0;

        // 1 reset with everyone requesting, then master 0 wins first
        for (int i = 0; i < 3; i++) step(0, 16'hFFFF, 0, 16'h0000, 0, "reset_hold");
        step(1, 16'hFFFF, 0, 16'h0001, 0, "first_pick_m0");
        step(1, 16'h0000, 0, 16'h0000, 0, "release_to_idle");

        // 2 latency and release
        step(1, 16'h0004, 0, 16'h0004, 0, "grant_latency");
        step(1, 16'h0004, 0, 16'h0004, 0, "grant_hold");
        step(1, 16'h0000, 0, 16'h0000, 0, "drop_release");

        // 3 rotation 0,2,15,0,2 without idle gaps (reset restores last=15)
        step(0, 16'h0000, 0, 16'h0000, 0, "reset_rot");
        step(1, 16'h8005, 0, 16'h0001, 0, "rot_m0");
        step(1, 16'h8004, 0, 16'h0004, 0, "rot_m2");
        step(1, 16'h8001, 0, 16'h8000, 0, "rot_m15");
        step(1, 16'h0005, 0, 16'h0001, 0, "rot_wrap_m0");
        step(1, 16'h8004, 0, 16'h0004, 0, "rot_m2_again");
        step(1, 16'h0000, 0, 16'h0000, 0, "rot_idle");

        // 4 preemption after MAX_HOLD contested cycles
        step(1, 16'h0001, 0, 16'h0001, 0, "pre_own_m0");
        for (int i = 0; i < 4; i++) step(1, 16'h0009, 0, 16'h0001, 0, "pre_contested");
        step(1, 16'h0009, 0, 16'h0008, 1, "pre_fire");
        step(1, 16'h0009, 0, 16'h0008, 0, "pre_pulse_end");
        step(1, 16'h0001, 0, 16'h0001, 0, "pre_m0_regain");
        step(1, 16'h0000, 0, 16'h0000, 0, "pre_idle");

        // 5 busy freezes the grant past MAX_HOLD
        step(1, 16'h0001, 0, 16'h0001, 0, "busy_own_m0");
        for (int i = 0; i < 10; i++) step(1, 16'h0009, 1, 16'h0001, 0, "busy_frozen");
        step(1, 16'h0009, 0, 16'h0008, 1, "busy_lift_preempt");
        step(1, 16'h0000, 0, 16'h0000, 0, "busy_idle");

        // release coinciding with expiry is a plain release
        step(1, 16'h0001, 0, 16'h0001, 0, "rx_own_m0");
        for (int i = 0; i < 4; i++) step(1, 16'h0009, 0, 16'h0001, 0, "rx_contested");
        step(1, 16'h0008, 0, 16'h0008, 0, "rx_release_no_preempt");
        step(1, 16'h0000, 0, 16'h0000, 0, "rx_idle");

        // 6 uncontested owner never ages; reset mid-grant drops it
        for (int i = 0; i < 100; i++) step(1, 16'h0002, 0, 16'h0002, 0, "uncontested_m1");
        step(0, 16'h0002, 0, 16'h0000, 0, "reset_mid_grant");
        step(1, 16'h0000, 0, 16'h0000, 0, "post_reset_idle");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
